mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester (IFU fetch, LSU load/store) arbiter in front of a single
// memory port, with at most one transaction outstanding. A request is
// granted combinationally in IDLE. The granted request is captured into
// registers and presented downstream in REQ. Once the memory accepts it,
// the arbiter waits for the response in WAIT. If no response arrives within
// TIMEOUT+1 WAIT cycles, the transaction is aborted.
//
// When both requesters are valid together, the one that did not win the
// previous grant wins this one.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   ifu_req_valid/ready       IFU request handshake; ifu_addr = fetch address
//   ifu_resp_valid, ifu_rdata IFU one-cycle completion and read data
//   lsu_req_valid/ready       LSU request handshake
//   lsu_addr, lsu_wen,        LSU address, store enable, store data and
//   lsu_wdata, lsu_wmask      byte mask
//   lsu_resp_valid, lsu_rdata LSU one-cycle completion and load data
//   mem_req_valid/ready       downstream request handshake
//   mem_addr, mem_wen,        registered request fields, held stable
//   mem_wdata, mem_wmask      while in REQ
//   mem_resp_valid, mem_rdata downstream response
//   err_timeout               one-cycle pulse when a transaction is aborted
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [7:0]            lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // The wait counter is 8 bits wide, so the abort threshold is truncated
    // to 8 bits.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_owner_q, last_owner_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wmask_q, wmask_d;

    logic                  grant_ifu;
    logic                  grant_lsu;
    logic                  resp_done;     // real memory response for the owner
    logic                  resp_abort;    // timeout abort

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_owner_q <= OWN_IFU;
            cnt_q        <= 8'd0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        grant_ifu    = 1'b0;
        grant_lsu    = 1'b0;
        resp_done    = 1'b0;
        resp_abort   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ifu_req_valid && lsu_req_valid) begin
                    grant_lsu = (last_owner_q == OWN_IFU);
                    grant_ifu = (last_owner_q == OWN_LSU);
                end else begin
                    grant_ifu = ifu_req_valid;
                    grant_lsu = lsu_req_valid;
                end

                if (grant_lsu) begin
                    state_d      = ST_REQ;
                    owner_d      = OWN_LSU;
                    last_owner_d = OWN_LSU;
                    addr_d       = lsu_addr;
                    wen_d        = lsu_wen;
                    wdata_d      = lsu_wdata;
                    wmask_d      = lsu_wmask;
                end else if (grant_ifu) begin
                    state_d      = ST_REQ;
                    owner_d      = OWN_IFU;
                    last_owner_d = OWN_IFU;
                    addr_d       = ifu_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wmask_d      = 8'd0;
                end
            end

            ST_REQ: begin
                // A response without acceptance is a stale one and is dropped.
                if (mem_req_ready) begin
                    if (mem_resp_valid) begin
                        resp_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_WAIT;
                        cnt_d     = 8'd0;
                    end
                end
            end

            ST_WAIT: begin
                if (mem_resp_valid) begin
                    resp_done  = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    resp_abort = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and response outputs are suppressed while rst is high. This
    // way a reset in REQ/WAIT never completes the transaction, even if a
    // response arrives in the same cycle.
    always_comb begin
        ifu_req_ready  = grant_ifu & ~rst;
        lsu_req_ready  = grant_lsu & ~rst;

        ifu_resp_valid = (resp_done | resp_abort) & (owner_q == OWN_IFU) & ~rst;
        lsu_resp_valid = (resp_done | resp_abort) & (owner_q == OWN_LSU) & ~rst;

        ifu_rdata      = (resp_done & (owner_q == OWN_IFU) & ~rst) ? mem_rdata : '0;
        lsu_rdata      = (resp_done & (owner_q == OWN_LSU) & ~rst) ? mem_rdata : '0;

        err_timeout    = resp_abort & ~rst;
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Inputs change 1 ns after a rising edge.
// Outputs are sampled 1 ns after that, so they are never read at an edge.
// Each scenario task carries its own comparisons against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        err_timeout;

    int vectors;
    int miscompares;

    mem_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = 32'h0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = 32'h0;
        lsu_wen        = 1'b0;
        lsu_wdata      = 32'h0;
        lsu_wmask      = 8'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req_valid got %b want 0", mem_req_valid); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got %h want 00000000", mem_addr); end
        vectors++; if ({mem_wen, mem_wmask} !== 9'h0) begin miscompares++; $display("FAIL rst_mem_wen_wmask got %h want 000", {mem_wen, mem_wmask}); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got %h want 00000000", mem_wdata); end
        vectors++; if ({ifu_resp_valid, lsu_resp_valid, err_timeout} !== 3'b000) begin miscompares++; $display("FAIL rst_resp got %b want 000", {ifu_resp_valid, lsu_resp_valid, err_timeout}); end
        vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin miscompares++; $display("FAIL rst_ready_idle got %b want 00", {ifu_req_ready, lsu_req_ready}); end
        vectors++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", {ifu_rdata, lsu_rdata}); end
        $display("txn reset done");
    endtask

    // IFU fetch with a one-cycle wait: grant c0, REQ c1, WAIT c2, response c3.
    task automatic test_ifu_fetch();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        settle();
        vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin miscompares++; $display("FAIL fetch_c0_ready got %b want 10", {ifu_req_ready, lsu_req_ready}); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_c0_mem_req_valid got %b want 0", mem_req_valid); end
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h1111_1111;
        mem_req_ready = 1'b1;
        settle();
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_c1_mem_req_valid got %b want 1", mem_req_valid); end
        vectors++; if (mem_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL fetch_c1_mem_addr got %h want 80000000", mem_addr); end
        vectors++; if ({mem_wen, mem_wmask, mem_wdata} !== 41'h0) begin miscompares++; $display("FAIL fetch_c1_wfields got %h want 0", {mem_wen, mem_wmask, mem_wdata}); end
        vectors++; if (ifu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_c1_resp got %b want 0", ifu_resp_valid); end
        tick();
        mem_req_ready = 1'b0;
        settle();
        vectors++; if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL fetch_c2_wait got %b want 00", {mem_req_valid, ifu_resp_valid}); end
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0413;
        settle();
        vectors++; if (ifu_resp_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_c3_resp_valid got %b want 1", ifu_resp_valid); end
        vectors++; if (ifu_rdata !== 32'h0000_0413) begin miscompares++; $display("FAIL fetch_c3_rdata got %h want 00000413", ifu_rdata); end
        vectors++; if ({lsu_resp_valid, lsu_rdata} !== 33'h0) begin miscompares++; $display("FAIL fetch_c3_lsu_quiet got %h want 0", {lsu_resp_valid, lsu_rdata}); end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        settle();
        vectors++; if ({ifu_resp_valid, ifu_rdata} !== 33'h0) begin miscompares++; $display("FAIL fetch_c4_resp_pulse got %h want 0", {ifu_resp_valid, ifu_rdata}); end
        $display("txn ifu fetch addr=80000000 rdata=00000413");
    endtask

    // Both held valid from reset: grants go LSU, IFU, LSU.
    task automatic test_arbitration();
        logic [1:0]  exp_ready [3];
        logic [31:0] exp_addr  [3];
        logic [31:0] rdata_v   [3];
        exp_ready[0] = 2'b01; exp_addr[0] = 32'h0000_2000; rdata_v[0] = 32'hA0A0_0001;
        exp_ready[1] = 2'b10; exp_addr[1] = 32'h0000_1000; rdata_v[1] = 32'hB0B0_0002;
        exp_ready[2] = 2'b01; exp_addr[2] = 32'h0000_2000; rdata_v[2] = 32'hC0C0_0003;

        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_1000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_2000;
        for (int k = 0; k < 3; k++) begin
            settle();
            vectors++; if ({ifu_req_ready, lsu_req_ready} !== exp_ready[k]) begin miscompares++; $display("FAIL arb_grant%0d got %b want %b", k, {ifu_req_ready, lsu_req_ready}, exp_ready[k]); end
            tick();
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'b1;
            mem_rdata      = rdata_v[k];
            settle();
            vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin miscompares++; $display("FAIL arb_req%0d_ready got %b want 00", k, {ifu_req_ready, lsu_req_ready}); end
            vectors++; if (mem_addr !== exp_addr[k]) begin miscompares++; $display("FAIL arb_req%0d_addr got %h want %h", k, mem_addr, exp_addr[k]); end
            if (exp_ready[k] == 2'b01) begin
                vectors++; if ({lsu_resp_valid, lsu_rdata, ifu_resp_valid} !== {1'b1, rdata_v[k], 1'b0}) begin miscompares++; $display("FAIL arb_resp%0d_lsu got %b/%h ifu %b want 1/%h ifu 0", k, lsu_resp_valid, lsu_rdata, ifu_resp_valid, rdata_v[k]); end
            end else begin
                vectors++; if ({ifu_resp_valid, ifu_rdata, lsu_resp_valid} !== {1'b1, rdata_v[k], 1'b0}) begin miscompares++; $display("FAIL arb_resp%0d_ifu got %b/%h lsu %b want 1/%h lsu 0", k, ifu_resp_valid, ifu_rdata, lsu_resp_valid, rdata_v[k]); end
            end
            $display("txn arbitration grant %0d %s", k, (exp_ready[k] == 2'b01) ? "lsu" : "ifu");
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_rdata      = 32'h0;
        end
        idle_inputs();
        settle();
    endtask

    // Store held in REQ for three cycles; fields must not follow the LSU inputs.
    task automatic test_store();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        settle();
        vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin miscompares++; $display("FAIL store_grant got %b want 01", {ifu_req_ready, lsu_req_ready}); end
        tick();
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h5555_5555;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0BAD_0BAD;
        lsu_wmask     = 8'hF0;
        for (int c = 0; c < 4; c++) begin
            mem_req_ready  = (c == 3);
            // Stale response while not accepted must be dropped.
            mem_resp_valid = (c == 1);
            mem_rdata      = 32'h7777_7777;
            settle();
            vectors++; if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F}) begin miscompares++; $display("FAIL store_hold%0d got v=%b a=%h w=%b d=%h m=%h want 1/80001000/1/deadbeef/0f", c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); end
            vectors++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL store_noresp%0d got %b want 00", c, {lsu_resp_valid, ifu_resp_valid}); end
            tick();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_F00D;
        settle();
        vectors++; if ({lsu_resp_valid, lsu_rdata} !== {1'b1, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL store_resp got %b/%h want 1/cafef00d", lsu_resp_valid, lsu_rdata); end
        vectors++; if ({ifu_resp_valid, ifu_rdata, err_timeout} !== 34'h0) begin miscompares++; $display("FAIL store_ifu_quiet got %h want 0", {ifu_resp_valid, ifu_rdata, err_timeout}); end
        $display("txn lsu store addr=80001000 wdata=deadbeef wmask=0f");
        tick();
        idle_inputs();
        settle();
    endtask

    // Accept and respond in the same REQ cycle.
    task automatic test_zero_latency();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0040;
        tick();
        ifu_req_valid  = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        settle();
        vectors++; if ({ifu_resp_valid, ifu_rdata} !== {1'b1, 32'h1234_5678}) begin miscompares++; $display("FAIL zl_resp got %b/%h want 1/12345678", ifu_resp_valid, ifu_rdata); end
        tick();
        idle_inputs();
        lsu_req_valid = 1'b1;
        settle();
        vectors++; if ({mem_req_valid, lsu_req_ready, ifu_resp_valid} !== 3'b010) begin miscompares++; $display("FAIL zl_idle_next got %b want 010", {mem_req_valid, lsu_req_ready, ifu_resp_valid}); end
        lsu_req_valid = 1'b0;
        settle();
        $display("txn ifu zero-latency rdata=12345678");
    endtask

    // No response after acceptance: abort on the 256th WAIT cycle.
    task automatic test_timeout();
        int early;
        early = 0;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_3000;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rdata     = 32'hFFFF_FFFF;
        for (int w = 1; w <= 255; w++) begin
            settle();
            if (lsu_resp_valid !== 1'b0 || err_timeout !== 1'b0) early++;
            tick();
        end
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL to_early got %0d early cycles want 0", early); end
        settle();
        vectors++; if ({lsu_resp_valid, lsu_rdata, err_timeout} !== {1'b1, 32'h0, 1'b1}) begin miscompares++; $display("FAIL to_abort got %b/%h err=%b want 1/00000000 err=1", lsu_resp_valid, lsu_rdata, err_timeout); end
        vectors++; if ({ifu_resp_valid, ifu_rdata} !== 33'h0) begin miscompares++; $display("FAIL to_ifu_quiet got %h want 0", {ifu_resp_valid, ifu_rdata}); end
        tick();
        settle();
        vectors++; if ({err_timeout, lsu_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL to_pulse got %b want 00", {err_timeout, lsu_resp_valid}); end
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h9999_9999;
        settle();
        vectors++; if ({lsu_resp_valid, lsu_rdata, ifu_resp_valid, err_timeout} !== 35'h0) begin miscompares++; $display("FAIL to_late_resp got %h want 0", {lsu_resp_valid, lsu_rdata, ifu_resp_valid, err_timeout}); end
        $display("txn lsu load timeout abort");
        tick();
        idle_inputs();
        settle();
    endtask

    // Reset in WAIT, with a response arriving in the same cycle.
    task automatic test_reset_in_wait();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0080;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h4444_4444;
        settle();
        vectors++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL rw_during got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
        tick();
        rst = 1'b0;
        settle();
        vectors++; if ({ifu_resp_valid, lsu_resp_valid, err_timeout, mem_req_valid} !== 4'b0000) begin miscompares++; $display("FAIL rw_after got %b want 0000", {ifu_resp_valid, lsu_resp_valid, err_timeout, mem_req_valid}); end
        vectors++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 73'h0) begin miscompares++; $display("FAIL rw_after_fields got %h want 0", {mem_addr, mem_wen, mem_wdata, mem_wmask}); end
        tick();
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h0000_00C0;
        settle();
        vectors++; if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL rw_next_grant got %b want 1", ifu_req_ready); end
        tick();
        ifu_req_valid  = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_ABCD;
        settle();
        vectors++; if ({mem_addr, ifu_resp_valid, ifu_rdata} !== {32'h0000_00C0, 1'b1, 32'h0000_ABCD}) begin miscompares++; $display("FAIL rw_next_resp got a=%h %b/%h want 000000c0 1/0000abcd", mem_addr, ifu_resp_valid, ifu_rdata); end
        $display("txn reset in wait, then ifu fetch rdata=0000abcd");
        tick();
        idle_inputs();
        settle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_ifu_fetch();
        test_arbitration();
        test_store();
        test_zero_latency();
        test_timeout();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
